m_cp0: RTL and testbench

Coprocessor-0 exception/interrupt controller at the M stage of the P7 pipeline. It receives exception flags produced upstream, including the E-stage ALU overflow flags (`Ov` for add/sub; address-add overflow remapped upstream to AdEL/AdES), and the six external hardware interrupt lines. It raises a flush/redirect request, latches EPC/Cause/SR state on entry, and clears EXL on `eret`. It also serves `mfc0`/`mtc0` accesses to SR(12), Cause(13), EPC(14) and PRId(15).

---
 rtl/m_cp0.sv | 119 +++++++++++
 tb/tb_m_cp0.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_cp0.sv
`default_nettype none
// ============================================================================
// Module   : m_cp0
// Brief    : Coprocessor-0 exception/interrupt controller for the M stage.
//            Raises a flush/redirect request, latches EPC/Cause/SR on entry,
//            clears EXL on eret and serves mfc0/mtc0 for SR/Cause/EPC/PRId.
// Revision : 1.0 - initial release
// ============================================================================
module m_cp0 #(
    parameter logic [31:0] PRID         = 32'h2021_0007,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hwint,
    input  logic        eret,
    output logic        req,
    output logic [31:0] handler_pc,
    output logic [31:0] epc_out
);

    localparam logic [4:0] c_ADDR_SR    = 5'd12;
    localparam logic [4:0] c_ADDR_CAUSE = 5'd13;
    localparam logic [4:0] c_ADDR_EPC   = 5'd14;
    localparam logic [4:0] c_ADDR_PRID  = 5'd15;

    // SR fields
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    // Cause fields
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    // EPC
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_wr_sr;
    logic        w_wr_epc;

    // EXL masks both sources so a handler is never re-entered.
    assign w_int_req  = (|(hwint & r_im)) & r_ie & ~r_exl;
    assign w_exc_req  = exc_valid & ~r_exl;
    assign req        = w_int_req | w_exc_req;
    assign w_wr_sr    = we && (addr == c_ADDR_SR);
    assign w_wr_epc   = we && (addr == c_ADDR_EPC);
    assign handler_pc = HANDLER_ADDR;
    assign epc_out    = r_epc;

    // SR: exception entry wins over mtc0 and eret; eret clears EXL after a same-cycle SR write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_im  <= 6'd0;
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
        end else if (req) begin
            r_exl <= 1'b1;
        end else begin
            if (w_wr_sr) begin
                r_im  <= wdata[15:10];
                r_exl <= wdata[1];
                r_ie  <= wdata[0];
            end
            if (eret) begin
                r_exl <= 1'b0;
            end
        end
    end

    // Cause: IP tracks the interrupt lines every edge; BD/ExcCode captured on entry only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ip       <= 6'd0;
            r_bd       <= 1'b0;
            r_exc_code <= 5'd0;
        end else begin
            r_ip <= hwint;
            if (req) begin
                r_bd       <= bd;
                r_exc_code <= w_int_req ? 5'd0 : exc_code;
            end
        end
    end

    // EPC: entry point of the faulting instruction, or the branch for a delay-slot victim.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_epc <= 32'd0;
        end else if (req) begin
            r_epc <= bd ? (pc - 32'd4) : pc;
        end else if (w_wr_epc) begin
            r_epc <= wdata;
        end
    end

    // mfc0 read mux; unimplemented registers and unstored bits read as zero.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            c_ADDR_SR:    rdata = {16'd0, r_im, 8'd0, r_exl, r_ie};
            c_ADDR_CAUSE: rdata = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};
            c_ADDR_EPC:   rdata = r_epc;
            c_ADDR_PRID:  rdata = PRID;
            default:      rdata = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_m_cp0.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_cp0
// Brief    : Scoreboard testbench for m_cp0. Expected values are queued when
//            stimulus is driven and compared against DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_cp0;

    localparam logic [31:0] c_PRID    = 32'h2021_0007;
    localparam logic [31:0] c_HANDLER = 32'h0000_4180;
    localparam int          c_RDATA   = 0;
    localparam int          c_REQ     = 1;
    localparam int          c_EPC     = 2;

    logic        clk;
    logic        reset_n;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        bd;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [5:0]  hwint;
    logic        eret;
    logic        req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    typedef struct {
        string       tag;
        int          sel;
        logic [4:0]  a;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    m_cp0 #(
        .PRID         (c_PRID),
        .HANDLER_ADDR (c_HANDLER)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .pc         (pc),
        .bd         (bd),
        .exc_valid  (exc_valid),
        .exc_code   (exc_code),
        .hwint      (hwint),
        .eret       (eret),
        .req        (req),
        .handler_pc (handler_pc),
        .epc_out    (epc_out)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [4:0] a, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.a   = a;
        e.v   = v;
        sb.push_back(e);
    endtask

    // Pop every queued expectation and compare it with the live outputs.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == c_RDATA) begin
                addr = e.a;
                #1;
                chk(e.tag, rdata, e.v);
            end else if (e.sel == c_REQ) begin
                #1;
                chk(e.tag, {31'd0, req}, e.v);
            end else begin
                #1;
                chk(e.tag, epc_out, e.v);
            end
        end
    endtask

    task automatic idle();
        we        = 1'b0;
        addr      = 5'd0;
        wdata     = 32'd0;
        pc        = 32'd0;
        bd        = 1'b0;
        exc_valid = 1'b0;
        exc_code  = 5'd0;
        eret      = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        we    = 1'b1;
        addr  = a;
        wdata = d;
        step();
        idle();
    endtask

    task automatic raise(input logic [31:0] p, input logic b, input logic [4:0] code);
        pc        = p;
        bd        = b;
        exc_valid = 1'b1;
        exc_code  = code;
    endtask

    initial begin
        idle();
        hwint   = 6'd0;
        reset_n = 1'b0;
        @(negedge clk);
        push("init_sr", c_RDATA, 5'd12, 32'd0);
        push("init_prid", c_RDATA, 5'd15, c_PRID);
        push("init_req", c_REQ, 5'd0, 32'd0);
        push("init_epc", c_EPC, 5'd0, 32'd0);
        drain();
        chk("handler_pc", handler_pc, c_HANDLER);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Mid-cycle asynchronous reset with SR fully set and IP/EPC non-zero
        mtc0(5'd14, 32'h0000_1234);
        hwint = 6'b101010;
        mtc0(5'd12, 32'h0000_FC03);
        push("pre_rst_sr", c_RDATA, 5'd12, 32'h0000_FC03);
        push("pre_rst_cause", c_RDATA, 5'd13, 32'h0000_A800);
        drain();
        #1;
        reset_n = 1'b0;
        push("rst_sr", c_RDATA, 5'd12, 32'd0);
        push("rst_cause", c_RDATA, 5'd13, 32'd0);
        push("rst_epc", c_RDATA, 5'd14, 32'd0);
        push("rst_req", c_REQ, 5'd0, 32'd0);
        drain();
        hwint = 6'd0;
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // ALU overflow, not in a delay slot
        mtc0(5'd12, 32'h0000_0001);
        raise(32'h0000_3010, 1'b0, 5'd12);
        push("ov_req", c_REQ, 5'd0, 32'd1);
        drain();
        step();
        idle();
        push("ov_epc", c_RDATA, 5'd14, 32'h0000_3010);
        push("ov_cause", c_RDATA, 5'd13, 32'h0000_0030);
        push("ov_sr", c_RDATA, 5'd12, 32'h0000_0003);
        push("ov_epc_out", c_EPC, 5'd0, 32'h0000_3010);
        drain();
        raise(32'h0000_3014, 1'b0, 5'd10);
        push("ov_masked_req", c_REQ, 5'd0, 32'd0);
        drain();
        step();
        idle();
        push("ov_masked_cause", c_RDATA, 5'd13, 32'h0000_0030);
        drain();

        // Address error in a branch delay slot
        mtc0(5'd12, 32'h0000_0001);
        raise(32'h0000_3014, 1'b1, 5'd4);
        push("bd_req", c_REQ, 5'd0, 32'd1);
        drain();
        step();
        idle();
        push("bd_epc", c_RDATA, 5'd14, 32'h0000_3010);
        push("bd_cause", c_RDATA, 5'd13, 32'h8000_0010);
        drain();

        // Interrupt beats a same-cycle exception
        mtc0(5'd12, 32'h0000_0401);
        hwint = 6'b000001;
        raise(32'h0000_3020, 1'b0, 5'd10);
        push("irq_req", c_REQ, 5'd0, 32'd1);
        drain();
        step();
        idle();
        push("irq_cause", c_RDATA, 5'd13, 32'h0000_0400);
        push("irq_sr", c_RDATA, 5'd12, 32'h0000_0403);
        push("irq_masked_req", c_REQ, 5'd0, 32'd0);
        drain();
        // IE cleared: only the exception is taken
        mtc0(5'd12, 32'h0000_0400);
        raise(32'h0000_3024, 1'b0, 5'd10);
        push("noie_req", c_REQ, 5'd0, 32'd1);
        drain();
        step();
        idle();
        push("noie_cause", c_RDATA, 5'd13, 32'h0000_0428);
        push("noie_epc", c_RDATA, 5'd14, 32'h0000_3024);
        drain();
        hwint = 6'd0;

        // req against a same-cycle mtc0 to EPC
        mtc0(5'd12, 32'h0000_0001);
        raise(32'h0000_3030, 1'b0, 5'd12);
        we    = 1'b1;
        addr  = 5'd14;
        wdata = 32'hDEAD_BEEF;
        push("col_we_req", c_REQ, 5'd0, 32'd1);
        drain();
        step();
        idle();
        push("col_we_epc", c_RDATA, 5'd14, 32'h0000_3030);
        push("col_we_sr", c_RDATA, 5'd12, 32'h0000_0003);
        drain();

        // req against a same-cycle eret
        mtc0(5'd12, 32'h0000_0001);
        raise(32'h0000_3040, 1'b0, 5'd12);
        eret = 1'b1;
        push("col_eret_req", c_REQ, 5'd0, 32'd1);
        drain();
        step();
        idle();
        push("col_eret_sr", c_RDATA, 5'd12, 32'h0000_0003);
        push("col_eret_epc", c_EPC, 5'd0, 32'h0000_3040);
        drain();

        // eret with a pending enabled interrupt
        mtc0(5'd14, 32'h0000_3010);
        mtc0(5'd12, 32'h0000_0403);
        hwint = 6'b000001;
        eret  = 1'b1;
        push("eret_epc_out", c_EPC, 5'd0, 32'h0000_3010);
        push("eret_req", c_REQ, 5'd0, 32'd0);
        drain();
        step();
        idle();
        push("post_eret_sr", c_RDATA, 5'd12, 32'h0000_0401);
        push("post_eret_epc", c_RDATA, 5'd14, 32'h0000_3010);
        push("post_eret_req", c_REQ, 5'd0, 32'd1);
        drain();

        // SR write and eret together: write lands, then EXL forced low
        hwint = 6'd0;
        step();
        we    = 1'b1;
        addr  = 5'd12;
        wdata = 32'h0000_0803;
        eret  = 1'b1;
        step();
        idle();
        push("wr_eret_sr", c_RDATA, 5'd12, 32'h0000_0801);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
